// File: rtl/rubik_ctrl_pkg.sv
// Shared types for the RUBIK register-group scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rubik_ctrl_pkg;

    // Default watchdog counter width.
    localparam int WDOG_W_DEF = 16;

    // Per-group state as seen by software; 2'd3 is never produced.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RUNNING = 2'd2
    } grp_status_e;

    // Engine sequencer states.
    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_START = 2'd1,
        E_BUSY  = 2'd2
    } eng_state_e;

endpackage

// File: rtl/rubik_grp_slot.sv
// Per-group IDLE/PENDING/RUNNING tracker.
// Latency: status and reject flag update one cycle after arm/launch/retire.
// Backpressure: an arm while not IDLE is dropped and flagged on busy_rej_o.
module rubik_grp_slot
    import rubik_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       arm_i,
    input  logic       launch_i,
    input  logic       retire_i,
    output logic [1:0] status_o,
    output logic       busy_rej_o
);

    grp_status_e st_q, st_d;
    logic        rej_q, rej_d;

    // Next state: arm only from IDLE; launch and retire only from their own source state.
    always_comb begin
        st_d  = st_q;
        rej_d = 1'b0;
        if (arm_i) begin
            if (st_q == ST_IDLE) begin
                st_d = ST_PENDING;
            end else begin
                rej_d = 1'b1;
            end
        end
        if (launch_i && (st_q == ST_PENDING)) begin
            st_d = ST_RUNNING;
        end
        if (retire_i && (st_q == ST_RUNNING)) begin
            st_d = ST_IDLE;
        end
    end

    // State and reject-pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q  <= ST_IDLE;
            rej_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            rej_q <= rej_d;
        end
    end

    assign status_o   = st_q;
    assign busy_rej_o = rej_q;

endmodule

// File: rtl/rubik_reg_group_ctrl.sv
// Ping-pong register-group scheduler: tracks two groups, launches and retires the datapath.
// Latency: arm visible next cycle; op_start two cycles after arming the consumer group.
// Backpressure: none; rejected writes and stray done pulses are reported on err_* pulses.
module rubik_reg_group_ctrl
    import rubik_ctrl_pkg::*;
#(
    parameter int WDOG_W = WDOG_W_DEF
) (
    input  logic              autosa_core_clk,
    input  logic              autosa_core_rst,
    input  logic              producer,
    input  logic              op_en_wr,
    input  logic              eng_done,
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic              consumer,
    output logic [1:0]        status_0,
    output logic [1:0]        status_1,
    output logic              cfg_group_sel,
    output logic              op_start,
    output logic              op_abort,
    output logic [1:0]        intr_done,
    output logic              intr_timeout,
    output logic              err_wr_busy,
    output logic              err_spurious_done
);

    eng_state_e        state_q, state_d;
    logic              consumer_q, consumer_d;
    logic              cfg_sel_q, cfg_sel_d;
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [1:0]        intr_done_q, intr_done_d;
    logic              timeout_q, timeout_d;
    logic              spur_q, spur_d;

    logic              cons_pending;
    logic              launch;
    logic              expire;
    logic              retire;
    logic [1:0]        grp_arm, grp_launch, grp_retire, grp_rej;
    logic [WDOG_W-1:0] wdog_lim_m1;

    // Engine sequencing, watchdog and pulse generation.
    always_comb begin
        state_d      = state_q;
        consumer_d   = consumer_q;
        cfg_sel_d    = cfg_sel_q;
        wdog_cnt_d   = wdog_cnt_q;
        intr_done_d  = 2'b00;
        timeout_d    = 1'b0;
        spur_d       = 1'b0;
        wdog_lim_m1  = wdog_limit - WDOG_W'(1);
        cons_pending = (consumer_q ? status_1 : status_0) == ST_PENDING;
        // Launch is registered on the way into E_START so RUNNING shows with op_start.
        launch       = (state_q == E_IDLE) && cons_pending;
        // Done in the same cycle as expiry takes priority.
        expire       = (state_q == E_BUSY) && !eng_done && (wdog_limit != '0)
                       && (wdog_cnt_q == wdog_lim_m1);
        retire       = (state_q == E_BUSY) && (eng_done || expire);

        unique case (state_q)
            E_IDLE: begin
                if (launch) begin
                    state_d   = E_START;
                    cfg_sel_d = consumer_q;
                end
            end
            E_START: begin
                state_d    = E_BUSY;
                wdog_cnt_d = '0;
            end
            E_BUSY: begin
                if (wdog_cnt_q != {WDOG_W{1'b1}}) begin
                    wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
                end
                if (retire) begin
                    state_d    = E_IDLE;
                    consumer_d = ~consumer_q;
                    if (eng_done) begin
                        intr_done_d = cfg_sel_q ? 2'b10 : 2'b01;
                    end else begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = E_IDLE;
        endcase

        if (eng_done && (state_q != E_BUSY)) begin
            spur_d = 1'b1;
        end
    end

    // Engine state and output-pulse registers.
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            state_q     <= E_IDLE;
            consumer_q  <= 1'b0;
            cfg_sel_q   <= 1'b0;
            wdog_cnt_q  <= '0;
            intr_done_q <= 2'b00;
            timeout_q   <= 1'b0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            consumer_q  <= consumer_d;
            cfg_sel_q   <= cfg_sel_d;
            wdog_cnt_q  <= wdog_cnt_d;
            intr_done_q <= intr_done_d;
            timeout_q   <= timeout_d;
            spur_q      <= spur_d;
        end
    end

    assign grp_arm    = {op_en_wr & producer, op_en_wr & ~producer};
    assign grp_launch = {launch & consumer_q, launch & ~consumer_q};
    assign grp_retire = {retire & cfg_sel_q, retire & ~cfg_sel_q};

    rubik_grp_slot u_slot0 (
        .clk_i      (autosa_core_clk),
        .rst_i      (autosa_core_rst),
        .arm_i      (grp_arm[0]),
        .launch_i   (grp_launch[0]),
        .retire_i   (grp_retire[0]),
        .status_o   (status_0),
        .busy_rej_o (grp_rej[0])
    );

    rubik_grp_slot u_slot1 (
        .clk_i      (autosa_core_clk),
        .rst_i      (autosa_core_rst),
        .arm_i      (grp_arm[1]),
        .launch_i   (grp_launch[1]),
        .retire_i   (grp_retire[1]),
        .status_o   (status_1),
        .busy_rej_o (grp_rej[1])
    );

    assign consumer          = consumer_q;
    assign cfg_group_sel     = (state_q == E_IDLE) ? consumer_q : cfg_sel_q;
    assign op_start          = (state_q == E_START);
    assign op_abort          = timeout_q;
    assign intr_timeout      = timeout_q;
    assign intr_done         = intr_done_q;
    assign err_wr_busy       = |grp_rej;
    assign err_spurious_done = spur_q;

endmodule

// File: tb/tb_rubik_reg_group_ctrl.sv
// Bench for the RUBIK register-group scheduler.
// Latency: n/a.
// Backpressure: n/a.
module tb_rubik_reg_group_ctrl;

    logic        clk;
    logic        rst;
    logic        producer;
    logic        op_en_wr;
    logic        eng_done;
    logic [15:0] wdog_limit;
    logic        consumer;
    logic [1:0]  status_0;
    logic [1:0]  status_1;
    logic        cfg_group_sel;
    logic        op_start;
    logic        op_abort;
    logic [1:0]  intr_done;
    logic        intr_timeout;
    logic        err_wr_busy;
    logic        err_spurious_done;

    rubik_reg_group_ctrl dut (
        .autosa_core_clk   (clk),
        .autosa_core_rst   (rst),
        .producer          (producer),
        .op_en_wr          (op_en_wr),
        .eng_done          (eng_done),
        .wdog_limit        (wdog_limit),
        .consumer          (consumer),
        .status_0          (status_0),
        .status_1          (status_1),
        .cfg_group_sel     (cfg_group_sel),
        .op_start          (op_start),
        .op_abort          (op_abort),
        .intr_done         (intr_done),
        .intr_timeout      (intr_timeout),
        .err_wr_busy       (err_wr_busy),
        .err_spurious_done (err_spurious_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Expected output vector:
    // {op_start, op_abort, intr_done[1:0], intr_timeout, err_wr_busy, err_spurious_done,
    //  consumer, cfg_group_sel, status_0[1:0], status_1[1:0]}
    typedef struct {
        int          cyc;
        logic [12:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: group states, consumer pointer and the cycle op_start is shown.
    int   m_st[2];
    bit   m_cons;
    int   m_launch;
    bit   m_rg;
    int   lim;

    // Monitor: every cycle the DUT presents its outputs, pop and compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [12:0] act;
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            act = {op_start, op_abort, intr_done, intr_timeout, err_wr_busy,
                   err_spurious_done, consumer, cfg_group_sel, status_0, status_1};
            n_chk++;
            if (act === e.v) begin
                n_pass++;
            end else begin
                $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, act, e.v);
            end
        end
    end

    // Drive one cycle of inputs and push the expected outputs for the following cycle.
    task automatic step(input bit r, input bit w, input bit p, input bit d);
        exp_t       e;
        bit         busy, idle, ex;
        bit         st, ab, to, wb, sp, cfg;
        logic [1:0] idn;
        int         ns[2];
        @(posedge clk);
        #1;
        rst        = r;
        op_en_wr   = w;
        producer   = p;
        eng_done   = d;
        wdog_limit = 16'(lim);
        st = 0; ab = 0; to = 0; wb = 0; sp = 0; idn = 2'b00;
        if (r) begin
            m_st[0] = 0; m_st[1] = 0; m_cons = 0; m_launch = -1; m_rg = 0;
        end else begin
            busy = (m_launch >= 0) && (cyc > m_launch);
            idle = (m_launch < 0);
            ex   = busy && !d && (lim != 0) && ((cyc - m_launch - 1) == lim - 1);
            ns   = m_st;
            if (d && !busy) sp = 1;
            if (w) begin
                if (m_st[p] != 0) wb = 1;
                else ns[p] = 1;
            end
            if (busy && (d || ex)) begin
                ns[m_rg] = 0;
                if (d) idn[m_rg] = 1'b1;
                else begin to = 1; ab = 1; end
                m_cons   = !m_cons;
                m_launch = -1;
            end else if (idle && m_st[m_cons] == 1) begin
                ns[m_cons] = 2;
                m_rg       = m_cons;
                m_launch   = cyc + 1;
                st         = 1;
            end
            m_st = ns;
        end
        cfg   = (m_launch >= 0) ? m_rg : m_cons;
        e.cyc = cyc + 1;
        e.v   = {st, ab, idn, to, wb, sp, m_cons, cfg, 2'(m_st[0]), 2'(m_st[1])};
        exp_q.push_back(e);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Wait for the current/next launch, then pulse eng_done on busy cycle 'dly' after op_start.
    task automatic finish_op(input int dly, input bit wr_same);
        for (int i = 0; i < 300; i++) begin
            if (m_launch >= 0 && (cyc + 1) == (m_launch + dly)) begin
                step(0, wr_same, m_rg, 1);
                return;
            end
            step(0, 0, 0, 0);
        end
        n_chk++;
        $display("FAIL finish_op wait expired cyc=%0d launch=%0d dly=%0d", cyc, m_launch, dly);
    endtask

    int lims[6];

    initial begin
        rst = 1'b1; op_en_wr = 1'b0; producer = 1'b0; eng_done = 1'b0; wdog_limit = '0;
        m_st[0] = 0; m_st[1] = 0; m_cons = 0; m_launch = -1; m_rg = 0; lim = 0;
        lims = '{0, 1, 2, 5, 9, 30};

        // Reset, then a single operation on group 0 finishing 20 cycles after op_start.
        repeat (3) step(1, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({op_start, op_abort, intr_done, intr_timeout, err_wr_busy, err_spurious_done,
             consumer, cfg_group_sel, status_0, status_1} === 13'b0) begin
            n_pass++;
        end else begin
            $display("FAIL reset state cyc=%0d", cyc);
        end
        idle_n(5);
        step(0, 1, 0, 0);
        finish_op(20, 0);
        idle_n(3);

        // Both groups armed back-to-back; the second launches right after the first retires.
        step(0, 1, m_cons, 0);
        step(0, 1, !m_cons, 0);
        finish_op(6, 0);
        finish_op(4, 0);
        idle_n(3);

        // Writes to a PENDING, RUNNING, and just-finishing group are rejected.
        step(0, 1, m_cons, 0);
        step(0, 1, m_cons, 0);
        idle_n(3);
        step(0, 1, m_rg, 0);
        finish_op(5, 1);
        idle_n(3);

        // Watchdog expiry with limit 5, then limit 0 never aborts.
        lim = 5;
        step(0, 1, m_cons, 0);
        idle_n(12);
        lim = 0;
        step(0, 1, m_cons, 0);
        idle_n(60);
        finish_op(70, 0);
        idle_n(3);

        // Spurious done while idle; done exactly on the expiry cycle wins.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        lim = 5;
        step(0, 1, m_cons, 0);
        finish_op(5, 0);
        idle_n(3);

        // Reset while RUNNING, then a fresh operation.
        step(0, 1, m_cons, 0);
        idle_n(4);
        step(1, 0, 0, 0);
        idle_n(2);
        step(0, 1, m_cons, 0);
        finish_op(3, 0);
        idle_n(3);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if (i % 150 == 0) lim = lims[$urandom_range(0, 5)];
            step($urandom_range(0, 399) == 0, $urandom_range(0, 4) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end
        idle_n(2);
        repeat (3) @(negedge clk);

        if (n_pass != n_chk || exp_q.size() != 0) begin
            $display("FAIL summary: %0d/%0d passed, %0d unchecked", n_pass, n_chk, exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
